// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counter and sync generator for a VGA-style display.
// Counts pixel_x/pixel_y across the full line/frame including blanking, and
// derives active-video, per-line and per-frame strobes plus hsync/vsync.
// Every decoded output is registered from the *next* count, so it lines up
// with the pixel_x/pixel_y value in the same cycle. The monitor-facing syncs
// and blank_n go through a PIPE_DELAY-stage shift register so they can be
// aligned with a downstream pixel pipeline of that depth.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 800,
    parameter int   H_FP       = 56,
    parameter int   H_SYNC     = 120,
    parameter int   H_BP       = 64,
    parameter int   V_ACTIVE   = 600,
    parameter int   V_FP       = 37,
    parameter int   V_SYNC     = 6,
    parameter int   V_BP       = 23,
    parameter logic SYNC_POL   = 1'b1,
    parameter int   PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] pixel_x,
    output logic [9:0]  pixel_y,
    output logic        videoEnable,
    output logic        frame_tick,
    output logic        line_tick,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sized copies of the boundaries so every compare is width-matched.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Idle value of one delay-line stage: {hsync, vsync, blank_n}.
    localparam logic [2:0] STAGE_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

    logic        x_wrap;
    logic [10:0] x_next;
    logic [9:0]  y_next;
    logic        ve_next;
    logic        ft_next;
    logic        lt_next;
    logic        hs_next;
    logic        vs_next;
    logic        hsync_int;
    logic        vsync_int;

    // Next raster position: x wraps at the end of the line, y advances on that wrap.
    always_comb begin
        x_wrap = (pixel_x == H_LAST);
        x_next = x_wrap ? 11'd0 : pixel_x + 11'd1;
        y_next = pixel_y;
        if (x_wrap) begin
            y_next = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
        end
    end

    // Decode from the next position so the registered flags match the registered counts.
    always_comb begin
        ve_next = (x_next < H_ACT) && (y_next < V_ACT);
        ft_next = (x_next == H_ACT_LAST) && (y_next == V_ACT_LAST);
        lt_next = (x_next == H_LAST);
        hs_next = ((x_next >= HS_START) && (x_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_next = ((y_next >= VS_START) && (y_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // Raster counters. Reset parks at (0,0), so the first edge afterwards shows (1,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_x <= 11'd0;
            pixel_y <= 10'd0;
        end else begin
            pixel_x <= x_next;
            pixel_y <= y_next;
        end
    end

    // Zero-skew status flags and internal syncs. videoEnable resets low, which
    // blanks pixel (0,0) of the first frame after reset only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            videoEnable <= 1'b0;
            frame_tick  <= 1'b0;
            line_tick   <= 1'b0;
            hsync_int   <= ~SYNC_POL;
            vsync_int   <= ~SYNC_POL;
        end else begin
            videoEnable <= ve_next;
            frame_tick  <= ft_next;
            line_tick   <= lt_next;
            hsync_int   <= hs_next;
            vsync_int   <= vs_next;
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_direct
            assign vga_hsync   = hsync_int;
            assign vga_vsync   = vsync_int;
            assign vga_blank_n = videoEnable;
        end else begin : g_delay
            logic [2:0] stage [PIPE_DELAY];

            // Delay line for the monitor outputs; reset clears every stage to idle
            // so nothing stale leaks out after a mid-frame reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stage[i] <= STAGE_IDLE;
                    end
                end else begin
                    stage[0] <= {hsync_int, vsync_int, videoEnable};
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign {vga_hsync, vga_vsync, vga_blank_n} = stage[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share clock and reset:
//   a: default 800x600 timing, SYNC_POL=1, PIPE_DELAY=2 (line-level checks)
//   b: tiny 16x10 raster, SYNC_POL=1, PIPE_DELAY=2 (frame-level and reset checks)
//   c: tiny 16x10 raster, SYNC_POL=0, PIPE_DELAY=0 (inverted, undelayed syncs)
// A reference raster model pushes the expected outputs of all three into
// exp_q on every clock edge; a monitor pops and compares on the falling edge.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [10:0] a_x, b_x, c_x;
    logic [9:0]  a_y, b_y, c_y;
    logic a_ve, a_ft, a_lt, a_hs, a_vs, a_bn;
    logic b_ve, b_ft, b_lt, b_hs, b_vs, b_bn;
    logic c_ve, c_ft, c_lt, c_hs, c_vs, c_bn;

    int checks = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .reset(reset), .pixel_x(a_x), .pixel_y(a_y), .videoEnable(a_ve),
        .frame_tick(a_ft), .line_tick(a_lt), .vga_hsync(a_hs), .vga_vsync(a_vs),
        .vga_blank_n(a_bn)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .PIPE_DELAY(2)
    ) dut_b (
        .clk(clk), .reset(reset), .pixel_x(b_x), .pixel_y(b_y), .videoEnable(b_ve),
        .frame_tick(b_ft), .line_tick(b_lt), .vga_hsync(b_hs), .vga_vsync(b_vs),
        .vga_blank_n(b_bn)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIPE_DELAY(0)
    ) dut_c (
        .clk(clk), .reset(reset), .pixel_x(c_x), .pixel_y(c_y), .videoEnable(c_ve),
        .frame_tick(c_ft), .line_tick(c_lt), .vga_hsync(c_hs), .vga_vsync(c_vs),
        .vga_blank_n(c_bn)
    );

    // ---------------- reference model ----------------
    localparam int   P_HA  [3] = '{800, 8, 8};
    localparam int   P_HF  [3] = '{56, 2, 2};
    localparam int   P_HS  [3] = '{120, 3, 3};
    localparam int   P_HB  [3] = '{64, 3, 3};
    localparam int   P_VA  [3] = '{600, 6, 6};
    localparam int   P_VF  [3] = '{37, 1, 1};
    localparam int   P_VS  [3] = '{6, 2, 2};
    localparam int   P_VB  [3] = '{23, 1, 1};
    localparam logic P_POL [3] = '{1'b1, 1'b1, 1'b0};
    localparam int   P_PD  [3] = '{2, 2, 0};

    logic [80:0] exp_q[$];
    int          mx [3];
    int          my [3];
    logic [2:0]  hist [3][8];

    function automatic logic [26:0] pack(input logic [10:0] x, input logic [9:0] y,
                                         input logic ve, input logic ft, input logic lt,
                                         input logic hs, input logic vs, input logic bn);
        return {x, y, ve, ft, lt, hs, vs, bn};
    endfunction

    // Returns {ve, ft, lt, hsync, vsync} for raster position (x,y) of instance k.
    function automatic logic [4:0] decode(input int x, input int y, input int k);
        logic ve, ft, lt, hs, vs;
        int ht;
        ht = P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k];
        ve = (x < P_HA[k]) && (y < P_VA[k]);
        ft = (x == P_HA[k] - 1) && (y == P_VA[k] - 1);
        lt = (x == ht - 1);
        hs = ((x >= P_HA[k] + P_HF[k]) && (x < P_HA[k] + P_HF[k] + P_HS[k])) ? P_POL[k] : ~P_POL[k];
        vs = ((y >= P_VA[k] + P_VF[k]) && (y < P_VA[k] + P_VF[k] + P_VS[k])) ? P_POL[k] : ~P_POL[k];
        return {ve, ft, lt, hs, vs};
    endfunction

    // hist[k][0] holds the current internal {hs, vs, ve}; hist[k][n] is n cycles old.
    always @(posedge clk or posedge reset) begin
        logic [80:0] e;
        logic [4:0]  d;
        logic [2:0]  o;
        int ht, vt;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                mx[k] = 0;
                my[k] = 0;
                for (int i = 0; i < 8; i++) hist[k][i] = {~P_POL[k], ~P_POL[k], 1'b0};
            end
        end else begin
            e = '0;
            for (int k = 0; k < 3; k++) begin
                ht = P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k];
                vt = P_VA[k] + P_VF[k] + P_VS[k] + P_VB[k];
                if (mx[k] == ht - 1) begin
                    mx[k] = 0;
                    my[k] = (my[k] == vt - 1) ? 0 : my[k] + 1;
                end else begin
                    mx[k] = mx[k] + 1;
                end
                d = decode(mx[k], my[k], k);
                for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = {d[1], d[0], d[4]};
                o = hist[k][P_PD[k]];
                e = {e[53:0], pack(11'(mx[k]), 10'(my[k]), d[4], d[3], d[2], o[2], o[1], o[0])};
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h (x,y,ve,ft,lt,hs,vs,bn)", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [80:0] e;
        if (reset) begin
            check_vec("reset_a", pack(a_x, a_y, a_ve, a_ft, a_lt, a_hs, a_vs, a_bn), 27'h0);
            check_vec("reset_b", pack(b_x, b_y, b_ve, b_ft, b_lt, b_hs, b_vs, b_bn), 27'h0);
            check_vec("reset_c", pack(c_x, c_y, c_ve, c_ft, c_lt, c_hs, c_vs, c_bn), 27'h6);
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow actual=0 entries expected=1");
        end else begin
            e = exp_q.pop_front();
            check_vec("sb_a", pack(a_x, a_y, a_ve, a_ft, a_lt, a_hs, a_vs, a_bn), e[80:54]);
            check_vec("sb_b", pack(b_x, b_y, b_ve, b_ft, b_lt, b_hs, b_vs, b_bn), e[53:27]);
            check_vec("sb_c", pack(c_x, c_y, c_ve, c_ft, c_lt, c_hs, c_vs, c_bn), e[26:0]);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lt_cnt, lt_last, lt_bad;
        int hs_rise_x, hs_hi, bn_fall_x, ve_fall_x;
        logic hs_prev, bn_prev, ve_prev;
        int ft_cnt, ft_last, ft_bad, wraps, wrap_bad, px, py;
        logic [15:0] c_hs_cols;
        logic [9:0]  c_vs_rows;
        logic found;
        int bn_rises, bn_rise_c, hs_changes;
        logic b_bn_prev, b_hs_prev;

        // Reset held for 5 cycles; monitor checks every cycle, plus hand values here.
        repeat (5) @(negedge clk);
        check("rst_a_x", 32'(a_x), 0);
        check("rst_a_hsync", 32'(a_hs), 0);
        check("rst_a_blank_n", 32'(a_bn), 0);
        check("rst_c_hsync_inv", 32'(c_hs), 1);
        check("rst_c_vsync_inv", 32'(c_vs), 1);
        #2 reset = 1'b0;

        lt_cnt = 0; lt_last = 0; lt_bad = 0;
        hs_rise_x = -1; hs_hi = 0; bn_fall_x = -1; ve_fall_x = -1;
        hs_prev = 1'b0; bn_prev = 1'b0; ve_prev = 1'b0;
        ft_cnt = 0; ft_last = 0; ft_bad = 0; wraps = 0; wrap_bad = 0; px = 0; py = 0;
        c_hs_cols = '0; c_vs_rows = '0;

        for (int c = 1; c <= 2090; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                check("first_edge_a_x", 32'(a_x), 1);
                check("first_edge_a_y", 32'(a_y), 0);
                check("first_edge_a_ve", 32'(a_ve), 1);
                check("first_edge_b_x", 32'(b_x), 1);
            end
            // dut_a: line timing
            if (a_lt) begin
                if (lt_cnt > 0 && c - lt_last != 1040) lt_bad++;
                if (a_x != 11'd1039) lt_bad++;
                lt_last = c;
                lt_cnt++;
            end
            if (a_hs) hs_hi++;
            if (!hs_prev && a_hs && hs_rise_x < 0) hs_rise_x = int'(a_x);
            if (bn_prev && !a_bn && bn_fall_x < 0) bn_fall_x = int'(a_x);
            if (ve_prev && !a_ve && ve_fall_x < 0) ve_fall_x = int'(a_x);
            hs_prev = a_hs; bn_prev = a_bn; ve_prev = a_ve;
            // dut_b: frame timing and wrap
            if (b_ft) begin
                if (ft_cnt > 0 && c - ft_last != 160) ft_bad++;
                if (b_x != 11'd7 || b_y != 10'd5) ft_bad++;
                ft_last = c;
                ft_cnt++;
            end
            if (px == 15 && py == 9) begin
                wraps++;
                if (b_x != 11'd0 || b_y != 10'd0) wrap_bad++;
            end
            px = int'(b_x); py = int'(b_y);
            // dut_c: inverted syncs, no delay
            if (!c_hs) c_hs_cols[c_x[3:0]] = 1'b1;
            if (!c_vs) c_vs_rows[c_y[3:0]] = 1'b1;
        end

        check("a_line_tick_count", 32'(lt_cnt), 2);
        check("a_line_tick_period", 32'(lt_bad), 0);
        check("a_vga_hsync_rise_x", 32'(hs_rise_x), 858);
        check("a_vga_hsync_high_cycles", 32'(hs_hi), 240);
        check("a_ve_fall_x", 32'(ve_fall_x), 800);
        check("a_blank_n_fall_x", 32'(bn_fall_x), 802);
        check("b_frame_tick_count", 32'(ft_cnt), 13);
        check("b_frame_tick_period_pos", 32'(ft_bad), 0);
        check("b_wrap_count", 32'(wraps), 13);
        check("b_wrap_to_origin", 32'(wrap_bad), 0);
        check("c_hsync_low_cols", 32'(c_hs_cols), 32'h1C00);
        check("c_vsync_low_rows", 32'(c_vs_rows), 32'h180);

        // Asynchronous reset between edges at raster (4,3) of dut_b.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #1;
            if (b_x == 11'd4 && b_y == 10'd3) found = 1'b1;
        end
        check("wait_b_at_4_3", 32'(found), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_b_x", 32'(b_x), 0);
        check("async_rst_b_y", 32'(b_y), 0);
        check("async_rst_b_blank_n", 32'(b_bn), 0);
        check("async_rst_a_x", 32'(a_x), 0);
        check("async_rst_c_hsync", 32'(c_hs), 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        bn_rises = 0; bn_rise_c = -1; hs_changes = 0;
        b_bn_prev = 1'b0; b_hs_prev = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                check("restart_b_x", 32'(b_x), 1);
                check("restart_b_y", 32'(b_y), 0);
                check("restart_b_ve", 32'(b_ve), 1);
            end
            if (!b_bn_prev && b_bn) begin
                bn_rises++;
                if (bn_rise_c < 0) bn_rise_c = c;
            end
            if (b_hs != b_hs_prev) hs_changes++;
            b_bn_prev = b_bn; b_hs_prev = b_hs;
        end
        check("restart_b_blank_n_rises", 32'(bn_rises), 1);
        check("restart_b_blank_n_rise_cycle", 32'(bn_rise_c), 3);
        check("restart_b_hsync_glitch", 32'(hs_changes), 0);

        repeat (400) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
